// File: rtl/trng_pkg.sv
// trng_pkg: shared defaults and pair-state encoding for the TRNG post-processor
package trng_pkg;
   localparam int TRNG_WIDTH = 8;
   localparam int TRNG_REP_LIMIT = 32;
   typedef enum logic {VN_EMPTY, VN_HAVE_FIRST} vn_state_e;
endpackage

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: von Neumann pair extractor, emits one debiased bit per 10/01 pair
module trng_vn_debias
   import trng_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic raw_bit,
   input  logic raw_valid,
   output logic vn_bit,
   output logic vn_valid
);
   vn_state_e state_q, state_d;
   logic first_q, first_d;
   logic accept;
   // The pulse is combinational so the packer updates on the same edge as the second sample
   always_comb begin
      accept = en && raw_valid;
      state_d = !en ? VN_EMPTY : accept ? (state_q == VN_EMPTY ? VN_HAVE_FIRST : VN_EMPTY) : state_q;
      first_d = (accept && state_q == VN_EMPTY) ? raw_bit : first_q;
      vn_valid = accept && state_q == VN_HAVE_FIRST && first_q != raw_bit;
      vn_bit = first_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= VN_EMPTY;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end
endmodule

// File: rtl/trng_postproc.sv
// trng_postproc: debias raw TRNG samples, pack them MSB-first into words and
// guard the source with a repetition-count health test
module trng_postproc
   import trng_pkg::*;
#(
   parameter int WIDTH = TRNG_WIDTH,
   parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             raw_bit,
   input  logic             raw_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             health_fail,
   output logic             overflow
);
   localparam int SW = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(REP_LIMIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
   localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);
   logic [SW-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rep_q, rep_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic prev_q, prev_d, valid_q, valid_d, hf_q, hf_d, ov_q, ov_d;
   logic accept, bit_ok, full, free, vn_bit, vn_valid;
   trng_vn_debias u_vn (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .raw_bit   (raw_bit),
      .raw_valid (raw_valid),
      .vn_bit    (vn_bit),
      .vn_valid  (vn_valid)
   );
   // A zero count marks "no previous sample", so the first sample starts a run of 1
   always_comb begin
      accept = en && raw_valid;
      rep_d = !accept ? rep_q : (rep_q != '0 && raw_bit == prev_q) ? (rep_q == REP_MAX ? rep_q : rep_q + 1'b1) : RW'(1);
      prev_d = accept ? raw_bit : prev_q;
      hf_d = hf_q || rep_d == REP_MAX;
      bit_ok = vn_valid && !hf_d;
      full = cnt_q == CNT_MAX;
      free = !valid_q || out_ready;
      shift_d = shift_q;
      cnt_d = cnt_q;
      data_d = data_q;
      valid_d = valid_q && !out_ready;
      ov_d = ov_q;
      if (bit_ok && !full) begin
         shift_d = SW'({shift_q, vn_bit});
         cnt_d = cnt_q + 1'b1;
      end else if (bit_ok && free) begin
         data_d = {shift_q, vn_bit};
         valid_d = 1'b1;
         cnt_d = '0;
      end else if (bit_ok) begin
         ov_d = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q <= '0;
         rep_q <= '0;
         prev_q <= 1'b0;
         data_q <= '0;
         valid_q <= 1'b0;
         hf_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q <= cnt_d;
         rep_q <= rep_d;
         prev_q <= prev_d;
         data_q <= data_d;
         valid_q <= valid_d;
         hf_q <= hf_d;
         ov_q <= ov_d;
      end
   end
   assign out_data = data_q;
   assign out_valid = valid_q;
   assign health_fail = hf_q;
   assign overflow = ov_q;
endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: directed and random stimulus against a queue-based reference model
module tb_trng_postproc;
   localparam int W = 8;
   localparam int L = 32;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, raw_bit = 1'b0, raw_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic out_valid, health_fail, overflow;
   int nchk = 0, nerr = 0;
   int m_half = -1, m_prev = -1, m_run = 0;
   bit pq[$];
   logic [W-1:0] m_data = '0;
   logic m_valid = 1'b0, m_hf = 1'b0, m_ov = 1'b0;
   always #5 clk = ~clk;
   trng_postproc #(.WIDTH(W), .REP_LIMIT(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .raw_bit     (raw_bit),
      .raw_valid   (raw_valid),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .health_fail (health_fail),
      .overflow    (overflow)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic mdl(input logic r, input logic e, input logic v, input logic b, input logic rdy);
      int nb;
      logic hf_n, nv;
      if (r) begin
         m_half = -1; m_prev = -1; m_run = 0; pq.delete();
         m_data = '0; m_valid = 0; m_hf = 0; m_ov = 0;
         return;
      end
      nb = -1;
      hf_n = m_hf;
      nv = m_valid && !rdy;
      if (e && v) begin
         m_run = (int'(b) == m_prev) ? ((m_run < L) ? m_run + 1 : L) : 1;
         m_prev = int'(b);
         if (m_run == L) hf_n = 1;
      end
      if (!e) m_half = -1;
      else if (v) begin
         if (m_half < 0) m_half = int'(b);
         else begin
            if (m_half != int'(b)) nb = m_half;
            m_half = -1;
         end
      end
      if (nb >= 0 && !hf_n) begin
         if (pq.size() < W - 1) pq.push_back(nb[0]);
         else if (!m_valid || rdy) begin
            m_data = '0;
            foreach (pq[i]) m_data = {m_data[W-2:0], pq[i]};
            m_data = {m_data[W-2:0], nb[0]};
            pq.delete();
            nv = 1;
         end else m_ov = 1;
      end
      m_valid = nv;
      m_hf = hf_n;
   endtask
   task automatic step(input logic r, input logic e, input logic v, input logic b, input logic rdy);
      rst = r; en = e; raw_valid = v; raw_bit = b; out_ready = rdy;
      @(posedge clk);
      mdl(r, e, v, b, rdy);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("health_fail", 32'(health_fail), 32'(m_hf));
      chk("overflow", 32'(overflow), 32'(m_ov));
   endtask
   task automatic pair(input logic a, input logic b, input logic rdy);
      step(0, 1, 1, a, rdy);
      step(0, 1, 1, b, rdy);
   endtask
   task automatic prod(input logic rdy, output logic a);
      a = 1'($urandom);
      pair(a, !a, rdy);
   endtask
   initial begin
      logic [1:0] tp [8] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
      logic [W-1:0] expw;
      logic a;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset_zero", {out_data, out_valid, health_fail, overflow}, 32'd0);
      for (int i = 0; i < 8; i++) pair(tp[i][1], tp[i][0], 0);
      chk("word_b2_valid", 32'(out_valid), 32'd1);
      chk("word_b2", 32'(out_data), 32'hB2);
      step(1, 0, 0, 0, 0);
      pair(0, 0, 0); pair(1, 1, 0); pair(0, 0, 0);
      for (int i = 0; i < 8; i++) pair(tp[i][1], tp[i][0], 0);
      chk("discard_b2", 32'(out_data), 32'hB2);
      for (int i = 0; i < 8; i++) prod(0, a);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_hold", 32'(out_data), 32'hB2);
      step(0, 1, 0, 0, 1);
      chk("drained", 32'(out_valid), 32'd0);
      pair(1, 0, 0);
      chk("reload_valid", 32'(out_valid), 32'd1);
      chk("reload_lsb", 32'(out_data[0]), 32'd1);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < L; i++) begin
         step(0, 1, 1, 1, 1);
         if (i == L - 2) chk("hf_31", 32'(health_fail), 32'd0);
      end
      chk("hf_32", 32'(health_fail), 32'd1);
      for (int i = 0; i < 8; i++) prod(0, a);
      chk("hf_no_word", 32'(out_valid), 32'd0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < L - 1; i++) step(0, 1, 1, 1, 1);
      step(0, 1, 1, 0, 1);
      chk("hf_31_then_0", 32'(health_fail), 32'd0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      pair(0, 1, 0);
      for (int i = 0; i < 7; i++) pair(1, 0, 0);
      chk("en_drop_word", 32'(out_data), 32'h7F);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) prod(0, a);
      step(0, 1, 0, 0, 1);
      for (int i = 0; i < L; i++) step(0, 1, 1, 1, 0);
      chk("pre_rst_hf", 32'(health_fail), 32'd1);
      chk("pre_rst_ov", 32'(overflow), 32'd1);
      step(1, 1, 1, 1, 0);
      chk("mid_rst_zero", {out_data, out_valid, health_fail, overflow}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         prod(0, a);
         expw = {expw[W-2:0], a};
      end
      chk("fresh_valid", 32'(out_valid), 32'd1);
      chk("fresh_word", 32'(out_data), 32'(expw));
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
              1'($urandom), $urandom_range(0, 2) == 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
